// File: rtl/friscv_proc_dispatch.sv
// In-order instruction dispatcher: a small FIFO feeds up to four execution
// units, gated by a register scoreboard (RAW/WAW), fence serialisation and unit readiness.
`ifndef INST_BUS_W
`define INST_BUS_W 32
`endif

module friscv_proc_dispatch #(
  parameter int NB_UNIT = 2,
  parameter int DEPTH   = 4,
  parameter int INSTW   = `INST_BUS_W
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 proc_en,
  output logic                 proc_ready,
  output logic                 proc_empty,
  input  logic [1:0]           inst_unit,
  input  logic                 inst_fence,
  input  logic                 inst_rd_wr,
  input  logic [4:0]           inst_rd,
  input  logic [4:0]           inst_rs1,
  input  logic [4:0]           inst_rs2,
  input  logic [INSTW-1:0]     inst_payload,
  output logic [NB_UNIT-1:0]   unit_en,
  output logic [INSTW-1:0]     unit_instbus,
  input  logic [NB_UNIT-1:0]   unit_ready,
  input  logic [NB_UNIT-1:0]   unit_empty,
  input  logic [NB_UNIT-1:0]   unit_rd_wr,
  input  logic [5*NB_UNIT-1:0] unit_rd_addr
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       unit;
    logic             fence;
    logic             rd_wr;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [INSTW-1:0] payload;
  } entry_t;

  entry_t      fifo [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] pending;
  logic [31:0] pending_nxt;

  logic not_empty;
  logic full;
  logic push;
  logic pop;
  logic unit_valid;
  logic hazard;
  logic fence_ok;
  logic issuable;
  logic issue_fire;

  assign head       = fifo[rd_ptr[AW-1:0]];
  assign not_empty  = (wr_ptr != rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign proc_ready = !full;
  assign push       = proc_en && !full;

  // Widened by one bit so NB_UNIT=4 compares without truncation.
  assign unit_valid = ({1'b0, head.unit} < 3'(NB_UNIT));
  assign hazard     = pending[head.rs1] || pending[head.rs2] ||
                      (head.rd_wr && pending[head.rd]);
  assign fence_ok   = !head.fence || ((pending == '0) && (&unit_empty));
  assign issuable   = not_empty && unit_valid && !hazard && fence_ok;

  always_comb begin
    for (int i = 0; i < NB_UNIT; i++) begin
      unit_en[i] = issuable && (head.unit == 2'(i));
    end
  end

  assign issue_fire   = |(unit_en & unit_ready);
  // Heads aimed at a non-existent unit are discarded without touching the scoreboard.
  assign pop          = issue_fire || (not_empty && !unit_valid);
  assign unit_instbus = head.payload;
  assign proc_empty   = !not_empty && (pending == '0) && (&unit_empty);

  always_comb begin
    // NOTE: start from the held value so every path assigns pending_nxt; no latch.
    pending_nxt = pending;
    for (int i = 0; i < NB_UNIT; i++) begin
      if (unit_rd_wr[i]) pending_nxt[unit_rd_addr[5*i +: 5]] = 1'b0;
    end
    if (issue_fire && head.rd_wr && (head.rd != 5'd0)) pending_nxt[head.rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pending <= pending_nxt;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo[wr_ptr[AW-1:0]] <= '{unit: inst_unit, fence: inst_fence, rd_wr: inst_rd_wr,
                                rd: inst_rd, rs1: inst_rs1, rs2: inst_rs2,
                                payload: inst_payload};
    end
  end

endmodule

// File: tb/tb_friscv_proc_dispatch.sv
// Directed bench for friscv_proc_dispatch (NB_UNIT=2, DEPTH=4, 32-bit payload).
module tb_friscv_proc_dispatch;

  logic        aclk = 1'b0;
  logic        srst;
  logic        proc_en;
  logic        proc_ready;
  logic        proc_empty;
  logic [1:0]  inst_unit;
  logic        inst_fence;
  logic        inst_rd_wr;
  logic [4:0]  inst_rd;
  logic [4:0]  inst_rs1;
  logic [4:0]  inst_rs2;
  logic [31:0] inst_payload;
  logic [1:0]  unit_en;
  logic [31:0] unit_instbus;
  logic [1:0]  unit_ready;
  logic [1:0]  unit_empty;
  logic [1:0]  unit_rd_wr;
  logic [9:0]  unit_rd_addr;

  int tests = 0;
  int fails = 0;

  friscv_proc_dispatch #(.NB_UNIT(2), .DEPTH(4), .INSTW(32)) dut (
    .aclk(aclk), .srst(srst), .proc_en(proc_en), .proc_ready(proc_ready),
    .proc_empty(proc_empty), .inst_unit(inst_unit), .inst_fence(inst_fence),
    .inst_rd_wr(inst_rd_wr), .inst_rd(inst_rd), .inst_rs1(inst_rs1),
    .inst_rs2(inst_rs2), .inst_payload(inst_payload), .unit_en(unit_en),
    .unit_instbus(unit_instbus), .unit_ready(unit_ready), .unit_empty(unit_empty),
    .unit_rd_wr(unit_rd_wr), .unit_rd_addr(unit_rd_addr)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [1:0] unit, input logic fence, input logic rd_wr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] pl);
    proc_en      = 1'b1;
    inst_unit    = unit;
    inst_fence   = fence;
    inst_rd_wr   = rd_wr;
    inst_rd      = rd;
    inst_rs1     = rs1;
    inst_rs2     = rs2;
    inst_payload = pl;
  endtask

  task automatic complete(input logic [1:0] wr, input logic [4:0] rd1, input logic [4:0] rd0);
    unit_rd_wr   = wr;
    unit_rd_addr = {rd1, rd0};
  endtask

  initial begin
    srst = 1'b1; proc_en = 1'b0; inst_unit = '0; inst_fence = 1'b0; inst_rd_wr = 1'b0;
    inst_rd = '0; inst_rs1 = '0; inst_rs2 = '0; inst_payload = '0;
    unit_ready = 2'b11; unit_empty = 2'b11; unit_rd_wr = '0; unit_rd_addr = '0;

    // Reset values
    tick(); tick(); #1;
    check("rst_ready", 32'(proc_ready), 32'd1);
    check("rst_unit_en", 32'(unit_en), 32'd0);
    check("rst_empty", 32'(proc_empty), 32'd1);
    unit_empty = 2'b01; #1;
    check("rst_empty_busy", 32'(proc_empty), 32'd0);
    unit_empty = 2'b11;
    tick(); srst = 1'b0;

    // Back-to-back: four independent instructions to units 0/1/0/1
    tick(); push(2'd0, 0, 1, 5'd1, 5'd0, 5'd0, 32'hA0); #1;
    check("b2b_c0_en", 32'(unit_en), 32'd0);
    tick(); push(2'd1, 0, 1, 5'd2, 5'd0, 5'd0, 32'hA1); #1;
    check("b2b_c1_en", 32'(unit_en), 32'b01);
    check("b2b_c1_bus", unit_instbus, 32'hA0);
    tick(); push(2'd0, 0, 1, 5'd3, 5'd0, 5'd0, 32'hA2); #1;
    check("b2b_c2_en", 32'(unit_en), 32'b10);
    check("b2b_c2_bus", unit_instbus, 32'hA1);
    tick(); push(2'd1, 0, 1, 5'd4, 5'd0, 5'd0, 32'hA3); #1;
    check("b2b_c3_en", 32'(unit_en), 32'b01);
    check("b2b_c3_bus", unit_instbus, 32'hA2);
    tick(); proc_en = 1'b0; #1;
    check("b2b_c4_en", 32'(unit_en), 32'b10);
    check("b2b_c4_bus", unit_instbus, 32'hA3);
    tick(); #1;
    check("b2b_c5_en", 32'(unit_en), 32'd0);
    check("b2b_pending_busy", 32'(proc_empty), 32'd0);
    complete(2'b11, 5'd2, 5'd1);
    tick(); complete(2'b11, 5'd4, 5'd3); #1;
    check("b2b_half_clear", 32'(proc_empty), 32'd0);
    tick(); complete(2'b00, 5'd0, 5'd0); #1;
    check("b2b_all_clear", 32'(proc_empty), 32'd1);

    // RAW on x5: consumer issues the cycle after the completion strobe
    tick(); push(2'd0, 0, 1, 5'd5, 5'd0, 5'd0, 32'hB0);
    tick(); push(2'd1, 0, 0, 5'd0, 5'd5, 5'd0, 32'hB1); #1;
    check("raw_prod_en", 32'(unit_en), 32'b01);
    tick(); proc_en = 1'b0; #1;
    check("raw_stall0", 32'(unit_en), 32'd0);
    tick(); #1;
    check("raw_stall1", 32'(unit_en), 32'd0);
    tick(); complete(2'b01, 5'd0, 5'd5); #1;
    check("raw_at_T", 32'(unit_en), 32'd0);
    tick(); complete(2'b00, 5'd0, 5'd0); #1;
    check("raw_at_T1", 32'(unit_en), 32'b10);
    check("raw_bus", unit_instbus, 32'hB1);
    tick(); #1;
    check("raw_done_en", 32'(unit_en), 32'd0);
    check("raw_done_empty", 32'(proc_empty), 32'd1);

    // Full FIFO: fifth push ignored, ready returns after the first pop
    unit_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick(); push(2'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h101 + 32'(i)); #1;
      check("full_fill_ready", 32'(proc_ready), 32'd1);
    end
    tick(); push(2'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h105); #1;
    check("full_ready", 32'(proc_ready), 32'd0);
    check("full_hold_en", 32'(unit_en), 32'b01);
    tick(); proc_en = 1'b0; unit_ready = 2'b01; #1;
    check("full_ready_prepop", 32'(proc_ready), 32'd0);
    check("full_head0", unit_instbus, 32'h101);
    for (int i = 1; i < 4; i++) begin
      tick(); #1;
      check("full_ready_after", 32'(proc_ready), 32'd1);
      check("full_drain_bus", unit_instbus, 32'h101 + 32'(i));
      check("full_drain_en", 32'(unit_en), 32'b01);
    end
    tick(); #1;
    check("full_no_fifth", 32'(unit_en), 32'd0);
    check("full_empty", 32'(proc_empty), 32'd1);

    // Fence: waits for x7 clear and all units idle
    unit_ready = 2'b11;
    tick(); push(2'd0, 0, 1, 5'd7, 5'd0, 5'd0, 32'hC0);
    tick(); push(2'd0, 1, 0, 5'd0, 5'd0, 5'd0, 32'hC1); #1;
    check("fence_prod_en", 32'(unit_en), 32'b01);
    tick(); proc_en = 1'b0; unit_empty = 2'b01; #1;
    check("fence_pend_stall", 32'(unit_en), 32'd0);
    tick(); complete(2'b01, 5'd0, 5'd7); #1;
    check("fence_clear_cycle", 32'(unit_en), 32'd0);
    tick(); complete(2'b00, 5'd0, 5'd0); #1;
    check("fence_unit_busy", 32'(unit_en), 32'd0);
    tick(); #1;
    check("fence_still_busy", 32'(unit_en), 32'd0);
    unit_empty = 2'b11; #1;
    check("fence_issue", 32'(unit_en), 32'b01);
    check("fence_bus", unit_instbus, 32'hC1);
    tick(); #1;
    check("fence_done", 32'(proc_empty), 32'd1);

    // Reset mid-flight with x3/x9 pending and three queued
    tick(); push(2'd0, 0, 1, 5'd3, 5'd0, 5'd0, 32'hD0);
    tick(); push(2'd1, 0, 1, 5'd9, 5'd0, 5'd0, 32'hD1);
    tick(); push(2'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'hD2); #1;
    check("rstmf_second_en", 32'(unit_en), 32'b10);
    tick(); unit_ready = 2'b00; push(2'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'hD3);
    tick(); push(2'd1, 0, 0, 5'd0, 5'd0, 5'd0, 32'hD4);
    tick(); proc_en = 1'b0; #1;
    check("rstmf_pre_empty", 32'(proc_empty), 32'd0);
    srst = 1'b1; unit_empty = 2'b01;
    tick(); srst = 1'b0; unit_ready = 2'b11; #1;
    check("rstmf_ready", 32'(proc_ready), 32'd1);
    check("rstmf_unit_en", 32'(unit_en), 32'd0);
    check("rstmf_busy", 32'(proc_empty), 32'd0);
    unit_empty = 2'b11; #1;
    check("rstmf_empty", 32'(proc_empty), 32'd1);
    tick(); #1;
    check("rstmf_no_issue", 32'(unit_en), 32'd0);

    // x0 writes never stall; unit index 3 is dropped
    tick(); push(2'd0, 0, 1, 5'd0, 5'd0, 5'd0, 32'hE0);
    tick(); push(2'd1, 0, 1, 5'd0, 5'd0, 5'd0, 32'hE1); #1;
    check("x0_first_en", 32'(unit_en), 32'b01);
    tick(); push(2'd3, 0, 1, 5'd6, 5'd0, 5'd0, 32'hE2); #1;
    check("x0_no_stall", 32'(unit_en), 32'b10);
    tick(); push(2'd0, 0, 0, 5'd0, 5'd0, 5'd0, 32'hE3); #1;
    check("inv_no_en", 32'(unit_en), 32'd0);
    check("inv_bus", unit_instbus, 32'hE2);
    tick(); proc_en = 1'b0; #1;
    check("inv_dropped_en", 32'(unit_en), 32'b01);
    check("inv_dropped_bus", unit_instbus, 32'hE3);
    tick(); #1;
    check("inv_no_pending", 32'(proc_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
